// File: rtl/note_tone_gen.sv
// note_tone_gen: latches one MIDI note per slot from the melody stream and
// renders it as a square-wave tone, a signed PCM sample and a note strobe.
module note_tone_gen #(
    parameter int unsigned        NOTE_CYCLES = 12_500_000,
    parameter int unsigned        GAP_CYCLES  = 1_250_000,
    parameter logic signed [15:0] AMPLITUDE   = 16'sd8000,
    parameter int unsigned        HP_SHIFT    = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               data_en,
    input  logic [7:0]         data,
    output logic               tone,
    output logic signed [15:0] sample,
    output logic               playing,
    output logic [7:0]         note_out,
    output logic               note_strobe
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    localparam logic [31:0] NOTE_LAST = NOTE_CYCLES - 1;
    localparam logic [31:0] GAP_LAST  = GAP_CYCLES - 1;

    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [16:0]        phase_q, phase_d;
    logic [16:0]        hp_q, hp_d;
    logic               tone_q, tone_d;
    logic               playing_q, playing_d;
    logic               sound_q, sound_d;
    logic               strobe_q, strobe_d;
    logic [7:0]         note_q, note_d;
    logic signed [15:0] sample_q, sample_d;

    function automatic logic is_note(input logic [7:0] n);
        return (n >= 8'd60) && (n <= 8'd83);
    endfunction

    // Upper octave reuses the base table at half the period.
    function automatic logic [16:0] lookup(input logic [7:0] n);
        logic [7:0]  idx;
        logic [16:0] base;
        logic [16:0] hp;
        idx = (n >= 8'd72) ? n - 8'd72 : n - 8'd60;
        case (idx)
            8'd0:    base = 17'd95556;
            8'd1:    base = 17'd90193;
            8'd2:    base = 17'd85131;
            8'd3:    base = 17'd80353;
            8'd4:    base = 17'd75843;
            8'd5:    base = 17'd71586;
            8'd6:    base = 17'd67568;
            8'd7:    base = 17'd63776;
            8'd8:    base = 17'd60196;
            8'd9:    base = 17'd56818;
            8'd10:   base = 17'd53629;
            8'd11:   base = 17'd50619;
            default: base = 17'd0;
        endcase
        hp = (n >= 8'd72) ? (base >> 1) : base;
        hp = hp >> HP_SHIFT;
        return (hp == '0) ? 17'd1 : hp;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            phase_q   <= '0;
            hp_q      <= 17'd1;
            tone_q    <= 1'b0;
            playing_q <= 1'b0;
            sound_q   <= 1'b0;
            strobe_q  <= 1'b0;
            note_q    <= '0;
            sample_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            hp_q      <= hp_d;
            tone_q    <= tone_d;
            playing_q <= playing_d;
            sound_q   <= sound_d;
            strobe_q  <= strobe_d;
            note_q    <= note_d;
            sample_q  <= sample_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (data_en) state_d = LOAD;
            LOAD: state_d = PLAY;
            PLAY: begin
                if (cnt_q == NOTE_LAST)
                    state_d = (GAP_CYCLES == 0) ? LOAD : GAP;
            end
            GAP:  if (cnt_q == GAP_LAST) state_d = LOAD;
            default: state_d = IDLE;
        endcase
        // Losing the stream beats slot expiry.
        if (!data_en) state_d = IDLE;
    end

    always_comb begin
        note_d  = note_q;
        hp_d    = hp_q;
        sound_d = sound_q;
        cnt_d   = '0;
        phase_d = '0;
        tone_d  = 1'b0;
        unique case (state_q)
            LOAD: begin
                note_d  = data;
                hp_d    = lookup(data);
                sound_d = is_note(data);
            end
            PLAY: begin
                cnt_d = cnt_q + 32'd1;
                if (sound_q) begin
                    if (phase_q == hp_q - 17'd1) begin
                        tone_d = ~tone_q;
                    end else begin
                        tone_d  = tone_q;
                        phase_d = phase_q + 17'd1;
                    end
                end
            end
            GAP:     cnt_d = cnt_q + 32'd1;
            default: ;
        endcase
        if (state_d != state_q) begin
            cnt_d   = '0;
            phase_d = '0;
            tone_d  = 1'b0;
        end
    end

    always_comb begin
        strobe_d  = (state_d == LOAD);
        playing_d = (state_d == PLAY) && sound_d;
        sample_d  = '0;
        if (playing_d)
            sample_d = tone_d ? AMPLITUDE : -AMPLITUDE;
    end

    assign tone        = tone_q;
    assign sample      = sample_q;
    assign playing     = playing_q;
    assign note_out    = note_q;
    assign note_strobe = strobe_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: slot-position reference model feeds an expected-output
// queue; a negedge monitor pops and compares every cycle.
module tb_note_tone_gen;

  localparam int NOTE  = 1000;
  localparam int GAP   = 10;
  localparam int SHIFT = 10;
  localparam int SLOT  = 1 + NOTE + GAP;
  localparam logic signed [15:0] AMP = 16'sd8000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic data_en = 1'b0;
  logic [7:0] data = 8'd0;
  logic tone;
  logic signed [15:0] sample;
  logic playing;
  logic [7:0] note_out;
  logic note_strobe;

  typedef struct packed {
    logic        tone;
    logic [15:0] sample;
    logic        playing;
    logic [7:0]  note;
    logic        strobe;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int passed = 0;

  bit         m_active = 0;
  int         m_pos = 0;
  logic [7:0] m_note = 8'd0;
  bit         m_snd = 0;
  int         m_hp = 1;
  int         base_hp[12] = '{95556, 90193, 85131, 80353, 75843, 71586,
                              67568, 63776, 60196, 56818, 53629, 50619};

  note_tone_gen #(
    .NOTE_CYCLES(NOTE),
    .GAP_CYCLES(GAP),
    .AMPLITUDE(AMP),
    .HP_SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .data_en(data_en),
    .data(data),
    .tone(tone),
    .sample(sample),
    .playing(playing),
    .note_out(note_out),
    .note_strobe(note_strobe)
  );

  always #5 clk = ~clk;

  function automatic int half_period(input int n);
    int h;
    h = base_hp[(n - 60) % 12] >> ((n - 60) / 12);
    h = h >> SHIFT;
    return (h == 0) ? 1 : h;
  endfunction

  function automatic void model_step();
    if (!resetn) begin
      m_active = 0;
      m_note = 8'd0;
    end else if (!data_en) begin
      m_active = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_pos = 0;
    end else begin
      if (m_pos == 0) begin
        m_note = data;
        m_snd = (data >= 60) && (data <= 83);
        if (m_snd) m_hp = half_period(int'(data));
      end
      m_pos = (m_pos + 1) % SLOT;
    end
  endfunction

  function automatic obs_t expected();
    obs_t e;
    int j;
    e = '0;
    e.note = m_note;
    if (m_active) begin
      e.strobe = (m_pos == 0);
      if (m_pos >= 1 && m_pos <= NOTE && m_snd) begin
        j = m_pos - 1;
        e.playing = 1'b1;
        e.tone = ((j / m_hp) % 2) == 1;
        e.sample = e.tone ? 16'(AMP) : 16'(-AMP);
      end
    end
    return e;
  endfunction

  task automatic cycle(input bit en, input logic [7:0] d, input bit rst_mid);
    @(posedge clk);
    model_step();
    #1;
    data_en = en;
    data = d;
    if (rst_mid) begin
      resetn = 1'b0;
      m_active = 0;
      m_note = 8'd0;
    end else begin
      resetn = 1'b1;
    end
    exp_q.push_back(expected());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: stimulus did not complete");
    $finish;
  end

  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.tone = tone;
        a.sample = sample;
        a.playing = playing;
        a.note = note_out;
        a.strobe = note_strobe;
        checks++;
        if (a == e) passed++;
        else $display("FAIL outputs t=%0t got tone=%0b sample=%0d playing=%0b note=%0d strobe=%0b want tone=%0b sample=%0d playing=%0b note=%0d strobe=%0b",
                      $time, a.tone, $signed(a.sample), a.playing, a.note, a.strobe,
                      e.tone, $signed(e.sample), e.playing, e.note, e.strobe);
      end
    end
  end

  initial begin
    int fr;
    cycle(0, 8'd0, 1);
    #1;
    checks++;
    if (tone === 1'b0 && sample === 16'sd0 && playing === 1'b0 &&
        note_out === 8'd0 && note_strobe === 1'b0)
      passed++;
    else $display("FAIL reset state t=%0t tone=%0b sample=%0d playing=%0b note=%0d strobe=%0b",
                  $time, tone, sample, playing, note_out, note_strobe);
    repeat (2) cycle(0, 8'd0, 1);
    repeat (3) cycle(0, 8'd0, 0);
    repeat (1200) cycle(1, 8'd60, 0);
    repeat (2) cycle(0, 8'd60, 0);
    repeat (1100) cycle(1, 8'd72, 0);
    cycle(0, 8'd72, 0);
    repeat (500) cycle(1, 8'd76, 0);
    cycle(1, 8'd76, 1);
    repeat (1100) cycle(1, 8'd76, 0);
    cycle(0, 8'd76, 0);
    repeat (2100) cycle(1, 8'd90, 0);
    cycle(0, 8'd90, 0);
    fr = 60;
    for (int i = 0; i < 3500; i++) begin
      cycle(1, 8'(fr), 0);
      fr = (fr == 76) ? 60 : fr + 4;
    end
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 499) != 0, 8'($urandom_range(50, 100)), 0);
    end
    repeat (2) cycle(0, 8'd0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Downstream consumer of the melody data generator. It samples the 8-bit MIDI note stream (`data`, qualified by `data_en`) once per note slot and converts the note into a square-wave tone for the audio path. It also produces a signed 16-bit PCM-style sample and a per-note strobe. It sits between the melody data generator and the audio codec / LED display logic.

## Interface
Parameters:
- NOTE_CYCLES, 12_500_000 — clocks a note sounds (0.25 s at 50 MHz); ≥1
- GAP_CYCLES, 1_250_000 — silent clocks between notes; 0 disables the gap
- AMPLITUDE, 16'sd8000 — sample magnitude while sounding
- HP_SHIFT, 0 — right-shift applied to the half-period table; simulation speed-up only

Ports:
- clk  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous, active-low reset
- data_en  in  1  upstream note stream valid (level)
- data  in  8  upstream MIDI note number
- tone  out  1  square-wave output
- sample  out  16  signed sample: +AMPLITUDE / −AMPLITUDE while sounding, 0 otherwise
- playing  out  1  high in PLAY state with a sounding (non-rest) note
- note_out  out  8  currently latched note
- note_strobe  out  1  one-cycle pulse when a new note is latched

## Operation
- Half-period table for the base octave, notes 60–71, in clocks at 50 MHz: 95556, 90193, 85131, 80353, 75843, 71586, 67568, 63776, 60196, 56818, 53629, 50619.
- Notes 72–83 use the entry for (n−12), shifted right by 1.
- The result is then shifted right by HP_SHIFT. A result of 0 is forced to 1.
- Notes outside 60–83 are rests: tone is held 0, sample is 0, playing is 0, and the slot timing is unchanged.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: outputs silent. Go to LOAD when data_en=1.
  - LOAD (1 clk):
    - note_out <= data
    - half_period <= lookup(data)
    - note_strobe = 1
    - phase <= 0, tone <= 0, slot counter <= 0
    - Next state: PLAY.
  - PLAY:
    - Slot counter increments every clock.
    - phase increments every clock; when phase = half_period−1, tone toggles and phase <= 0.
    - After NOTE_CYCLES clocks in PLAY, go to GAP, or straight to LOAD if GAP_CYCLES=0.
  - GAP: tone=0, sample=0, playing=0. After GAP_CYCLES clocks, go to LOAD.
- data_en=0 in any non-IDLE state → IDLE on the next clock. tone, phase and counters clear; note_out keeps its last value.
- data is sampled only in LOAD. Changes to data between loads are ignored, because upstream advances data every clock.
- Arithmetic:
  - phase and half_period are 17 bits.
  - The slot counter is 32 bits, unsigned.
  - sample is a registered two's-complement value, derived from the tone and playing values registered in the same cycle.

## Timing
- Reset values: tone=0, sample=0, playing=0, note_out=0, note_strobe=0, state=IDLE.
- Reset is asynchronous at any point, including mid-note. Outputs return to reset values immediately.
- data_en rising at edge k: LOAD during cycle k+1. note_strobe is high for that cycle only. note_out is valid from edge k+2.
- The first tone toggle occurs half_period clocks after entering PLAY.
- Note slot period = 1 (LOAD) + NOTE_CYCLES + GAP_CYCLES clocks. note_strobe pulses are spaced exactly by this period.
- playing rises on the first PLAY clock and falls on the first GAP clock.
- data_en falling and slot expiry in the same cycle: data_en wins → IDLE.

## Test plan
- Params NOTE_CYCLES=1000, GAP_CYCLES=10, HP_SHIFT=10. data=60, data_en raised → one note_strobe, note_out=60, tone toggles every 93 clocks, sample alternates +8000/−8000.
- Same params, data=72 at LOAD → half period 46 clocks. data=76 → 37 clocks (37921>>10).
- Free-running upstream (data 60→64→…→76→60, +4 per clock) → strobe spacing exactly 1011 clocks. Each latched note equals data in its LOAD cycle. sample=0 and playing=0 for 10 clocks between notes.
- data=90 (rest) → note_strobe pulses, note_out=90, tone=0, sample=0, playing=0 for the full slot. The next LOAD occurs on schedule.
- data_en dropped mid-PLAY → IDLE on the next clock, tone=0, sample=0. Re-raising data_en → fresh LOAD one clock later.
- resetn pulsed low mid-PLAY (asynchronous, between clock edges) → all outputs at reset values before the next edge. Normal operation resumes on data_en after release.
